stage_param_loader: RTL and testbench

STAGE_PARAM_LOADER -- requirements
Module: stage_param_loader

---
 rtl/stage_param_loader_if.sv | 34 +++
 rtl/stage_param_loader.sv | 155 +++++++++++++++
 tb/tb_stage_param_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stage_param_loader_if.sv
// Handshake/bus bundle between the stage parameter loader, its database and its consumer.
// Latency: none (wires only).
// Backpressure: carries the i_param_ready / o_param_valid record handshake.
interface stage_param_loader_if #(
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH_16            = 16,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18
);
    logic                                              i_start;
    logic [DATA_WIDTH_16-1:0]                          i_db_data;
    logic [ADDR_WIDTH-1:0]                             i_db_address;
    logic                                              o_db_ren;
    logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16-1:0] o_param_record;
    logic                                              o_param_valid;
    logic                                              i_param_ready;
    logic [7:0]                                        o_classifier_index;
    logic                                              o_busy;
    logic                                              o_stage_done;
    logic                                              o_seq_error;

    // Loader side.
    modport slave (
        input  i_start, i_db_data, i_db_address, i_param_ready,
        output o_db_ren, o_param_record, o_param_valid, o_classifier_index,
               o_busy, o_stage_done, o_seq_error
    );

    // Driver side (control, database and record consumer).
    modport master (
        output i_start, i_db_data, i_db_address, i_param_ready,
        input  o_db_ren, o_param_record, o_param_valid, o_classifier_index,
               o_busy, o_stage_done, o_seq_error
    );
endinterface

// File: rtl/stage_param_loader.sv
// Loads one classifier record at a time from the stage database and presents it to a consumer.
// Latency: start/accept to first read 1 cycle; record valid NUM_PARAM_PER_CLASSIFIER+2 cycles after.
// Backpressure: record held stable while not ready; no database reads until it is accepted.
module stage_param_loader #(
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH_16            = 16,
    parameter int NUM_CLASSIFIERS_STAGE    = 10,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18
) (
    input  logic                 clk_fpga,
    input  logic                 reset_fpga,
    stage_param_loader_if.slave  bus
);
    localparam int CW = $clog2(NUM_PARAM_PER_CLASSIFIER + 1);
    localparam int RW = NUM_PARAM_PER_CLASSIFIER * DATA_WIDTH_16;
    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_PARAM_PER_CLASSIFIER);
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [7:0]    LAST_CLS  = 8'(NUM_CLASSIFIERS_STAGE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         req_q, req_d;      // database reads issued for this classifier
    logic [CW-1:0]         cap_q, cap_d;      // words captured for this classifier
    logic [7:0]            idx_q, idx_d;
    logic                  ren_q, ren_d;
    logic                  pend_q;            // a read was issued last cycle, data arrives now
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [RW-1:0]         record_q;
    logic                  capture_en;
    logic [ADDR_WIDTH-1:0] exp_addr;

    // State register.
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and registered output values.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cap_d      = cap_q;
        idx_d      = idx_q;
        ren_d      = 1'b0;
        valid_d    = valid_q;
        done_d     = done_q;
        err_d      = err_q;
        capture_en = 1'b0;
        exp_addr   = ADDR_WIDTH'(int'(idx_q) * NUM_PARAM_PER_CLASSIFIER + int'(cap_q));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_d = ST_FILL;
                    idx_d   = 8'd0;
                    req_d   = CW'(1);
                    cap_d   = '0;
                    ren_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_FILL: begin
                // Issue exactly one read per word; the counter saturates at a full record.
                if (req_q < FULL_CNT) begin
                    ren_d = 1'b1;
                    req_d = req_q + CW'(1);
                end
                // Capture the word returned for last cycle's read and check its address.
                if (pend_q && (cap_q < FULL_CNT)) begin
                    capture_en = 1'b1;
                    cap_d      = cap_q + CW'(1);
                    if (bus.i_db_address != exp_addr) begin
                        err_d = 1'b1;
                    end
                    if (cap_q == LAST_WORD) begin
                        state_d = ST_PRESENT;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                if (valid_q && bus.i_param_ready) begin
                    valid_d = 1'b0;
                    if (idx_q < LAST_CLS) begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_FILL;
                        req_d   = CW'(1);
                        cap_d   = '0;
                        ren_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FILL) || (state_d == ST_PRESENT);
    end

    // Counters, flags and the record being assembled.
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            req_q    <= '0;
            cap_q    <= '0;
            idx_q    <= '0;
            ren_q    <= 1'b0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            record_q <= '0;
        end else begin
            req_q   <= req_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            ren_q   <= ren_d;
            pend_q  <= ren_q;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int p = 0; p < NUM_PARAM_PER_CLASSIFIER; p++) begin
                if (capture_en && (cap_q == CW'(p))) begin
                    record_q[p*DATA_WIDTH_16 +: DATA_WIDTH_16] <= bus.i_db_data;
                end
            end
        end
    end

    assign bus.o_db_ren           = ren_q;
    assign bus.o_param_record     = record_q;
    assign bus.o_param_valid      = valid_q;
    assign bus.o_classifier_index = idx_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_stage_done       = done_q;
    assign bus.o_seq_error        = err_q;
endmodule

// File: tb/tb_stage_param_loader.sv
// Directed bench for stage_param_loader with a 1-cycle-latency database model.
// Latency: checks read-enable and valid timing cycle by cycle.
// Backpressure: holds the consumer not-ready for 50 cycles at classifier 3.
module tb_stage_param_loader;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NC = 10;
    localparam int NP = 18;
    localparam int RW = NP * DW;

    logic          clk_fpga = 1'b0;
    logic          reset_fpga;
    logic          bad_en;
    logic [DW-1:0] db_data;
    logic [AW-1:0] db_addr;
    int            db_ptr;
    int            checks = 0;
    int            errors = 0;

    always #5 clk_fpga = ~clk_fpga;

    stage_param_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH_16(DW), .NUM_PARAM_PER_CLASSIFIER(NP)) bus ();

    stage_param_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH_16(DW),
        .NUM_CLASSIFIERS_STAGE(NC), .NUM_PARAM_PER_CLASSIFIER(NP)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .bus        (bus)
    );

    assign bus.i_db_data    = db_data;
    assign bus.i_db_address = db_addr;

    // Database: one word per read enable, served sequentially, word = address + 1.
    always @(posedge clk_fpga) begin
        if (reset_fpga) begin
            db_ptr  <= 0;
            db_data <= '0;
            db_addr <= '0;
        end else if (bus.o_db_ren) begin
            db_data <= DW'(db_ptr + 1);
            db_addr <= (bad_en && db_ptr == 41) ? '0 : AW'(db_ptr);
            db_ptr  <= (db_ptr == NC * NP - 1) ? 0 : db_ptr + 1;
        end
    end

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] exp_rec(input int c);
        logic [RW-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) r[p*DW +: DW] = DW'(NP * c + p + 1);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " flags"}, RW'({bus.o_db_ren, bus.o_param_valid, bus.o_busy,
                                    bus.o_stage_done, bus.o_seq_error}), '0);
        check({tag, " index"}, RW'(bus.o_classifier_index), '0);
        check({tag, " record"}, bus.o_param_record, '0);
    endtask

    // Entered one cycle after the start/accept edge; leaves in the cycle the record is valid.
    task automatic observe(input int c, input int pulse_t, input logic drop_ready,
                           input logic [19:0] err_exp);
        logic [19:0] rm, vm, em;
        for (int t = 0; t < 20; t++) begin
            rm[t] = bus.o_db_ren;
            vm[t] = bus.o_param_valid;
            em[t] = bus.o_seq_error;
            bus.i_start = (t == pulse_t);
            if (drop_ready && t == 18) bus.i_param_ready = 1'b0;
            if (t < 19) tick();
        end
        bus.i_start = 1'b0;
        check($sformatf("c%0d ren timing", c), RW'(rm), RW'(20'h3FFFF));
        check($sformatf("c%0d valid timing", c), RW'(vm), RW'(20'h80000));
        check($sformatf("c%0d seq_error", c), RW'(em), RW'(err_exp));
        check($sformatf("c%0d record", c), bus.o_param_record, exp_rec(c));
        check($sformatf("c%0d index", c), RW'(bus.o_classifier_index), RW'(c));
        check($sformatf("c%0d busy", c), RW'(bus.o_busy), RW'(1'b1));
    endtask

    task automatic run_stage(input logic bad, input logic backpressure, input logic pulses);
        logic [19:0] e;
        int          unstable;
        for (int c = 0; c < NC; c++) begin
            if (!bad || c < 2) e = 20'h0;
            else if (c == 2)   e = 20'hFFF80;
            else               e = 20'hFFFFF;
            observe(c, (pulses && c == 1) ? 5 : -1, backpressure && c == 3, e);
            if (backpressure && c == 3) begin
                unstable = 0;
                for (int i = 0; i < 50; i++) begin
                    bus.i_start = pulses && (i == 10);
                    tick();
                    if (bus.o_db_ren !== 1'b0 || bus.o_param_valid !== 1'b1 ||
                        bus.o_classifier_index !== 8'd3 || bus.o_param_record !== exp_rec(3))
                        unstable++;
                end
                bus.i_start = 1'b0;
                check("backpressure hold", RW'(unstable), '0);
                bus.i_param_ready = 1'b1;
            end
            tick();
        end
        check("done flag", RW'(bus.o_stage_done), RW'(1'b1));
        check("done idle outputs", RW'({bus.o_busy, bus.o_db_ren, bus.o_param_valid}), '0);
        check("done index", RW'(bus.o_classifier_index), RW'(NC - 1));
        check("done seq_error", RW'(bus.o_seq_error), RW'(bad));
    endtask

    initial begin
        reset_fpga        = 1'b1;
        bad_en            = 1'b0;
        bus.i_start       = 1'b0;
        bus.i_param_ready = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset");
        reset_fpga = 1'b0;
        tick(); tick();
        check("idle quiet", RW'({bus.o_db_ren, bus.o_busy, bus.o_param_valid}), '0);

        // Stage A: nominal load with backpressure at classifier 3 and ignored start pulses.
        bus.i_param_ready = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        run_stage(1'b0, 1'b1, 1'b1);

        // Stage B: restart from DONE with a corrupted address at classifier 2 word 5.
        bad_en = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("restart clears done", RW'(bus.o_stage_done), '0);
        run_stage(1'b1, 1'b0, 1'b0);
        bad_en = 1'b0;

        // Stage C: reset in the middle of classifier 1, then a clean reload.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        observe(0, -1, 1'b0, 20'hFFFFF);
        tick();
        for (int i = 0; i < 9; i++) tick();
        reset_fpga = 1'b1;
        tick();
        reset_fpga = 1'b0;
        check_all_zero("mid-fill reset");
        tick(); tick();
        check("post-reset idle", RW'({bus.o_db_ren, bus.o_busy, bus.o_param_valid}), '0);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        run_stage(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
